// File: rtl/adsb_frame_asm.sv
// ADS-B Mode S frame assembler: collects demodulated bits, computes CRC-24 serially and streams tagged records.
// Optional build macro ADSB_CRC_REJECT_EN drops DF11/17/18 frames whose syndrome is nonzero.
module adsb_frame_asm #(
    parameter int CONF_MAX = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        det_ena,
    input  logic        data_start,
    input  logic        bit_ena,
    input  logic        bit_data,
    input  logic        bit_conf,
    input  logic        done,
    input  logic        watchdog_reset,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [15:0] frames_ok,
    output logic [15:0] frames_bad,
    output logic        overrun,
    output logic [1:0]  state_dbg
);

    // Output stream: a byte moves on any cycle with out_valid && out_ready; out_data/out_last
    // hold while stalled and out_valid stays high from header to the last syndrome byte.

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_CHECK   = 2'd2,
        S_SEND    = 2'd3
    } state_t;

    localparam logic [23:0] CRC_POLY = 24'hFFF409;
    localparam logic [6:0]  CONF_LIM = (CONF_MAX > 63) ? 7'd63 : 7'(CONF_MAX);

    state_t state, state_nxt;

    logic [6:0]   bit_cnt;
    logic [5:0]   low_cnt;
    logic [23:0]  crc;
    logic [23:0]  parity;
    logic [111:0] shreg;
    logic [4:0]   df;
    logic [4:0]   byte_idx;

    logic        abort;
    logic        is_long;
    logic [6:0]  bit_num;
    logic [6:0]  frame_len;
    logic        bit_take;
    logic        frame_full;
    logic        in_crc_region;
    logic [23:0] syndrome;
    logic        crc_ok;
    logic        conf_fail;
    logic        crc_reject;
    logic        drop_early;
    logic        check_drop;
    logic        check_pass;
    logic        xfer;
    logic [3:0]  nbytes;
    logic [3:0]  byte_off;
    logic [4:0]  syn_sel;
    logic [4:0]  last_idx;
    logic [7:0]  nxt_byte;
    logic [7:0]  header;

    assign abort         = watchdog_reset || !det_ena;
    assign is_long       = df[4];
    assign bit_num       = bit_cnt + 7'd1;
    assign frame_len     = is_long ? 7'd112 : 7'd56;
    assign bit_take      = (state == S_COLLECT) && bit_ena && !abort;
    assign frame_full    = bit_take && (bit_num == frame_len);
    // DF is unknown during the first five bits, but those always fall in the CRC region.
    assign in_crc_region = (bit_num <= (frame_len - 7'd24));
    assign syndrome      = crc ^ parity;
    assign crc_ok        = (syndrome == 24'd0);
    assign conf_fail     = ({1'b0, low_cnt} > CONF_LIM);

`ifdef ADSB_CRC_REJECT_EN
    assign crc_reject = ((df == 5'd11) || (df == 5'd17) || (df == 5'd18)) && !crc_ok;
`else
    assign crc_reject = 1'b0;
`endif

    assign drop_early = (state == S_COLLECT) && !abort && !frame_full && done;
    assign check_drop = (state == S_CHECK) && !abort && (conf_fail || crc_reject);
    assign check_pass = (state == S_CHECK) && !abort && !(conf_fail || crc_reject);
    assign xfer       = (state == S_SEND) && out_valid && out_ready;

    assign header   = {is_long, crc_ok, low_cnt};
    assign nbytes   = is_long ? 4'd14 : 4'd7;
    assign last_idx = is_long ? 5'd17 : 5'd10;
    assign byte_off = nbytes - byte_idx[3:0];
    assign syn_sel  = byte_idx - {1'b0, nbytes};
    assign state_dbg = state;

    // Record byte at byte_idx (1-based after the header): frame bytes, then syndrome bytes.
    always_comb begin
        nxt_byte = 8'd0;
        if (byte_idx <= {1'b0, nbytes}) begin
            nxt_byte = shreg[{byte_off, 3'b000} +: 8];
        end else begin
            case (syn_sel)
                5'd1:    nxt_byte = syndrome[23:16];
                5'd2:    nxt_byte = syndrome[15:8];
                default: nxt_byte = syndrome[7:0];
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (data_start && det_ena && !watchdog_reset) state_nxt = S_COLLECT;
            end
            S_COLLECT: begin
                if (abort)           state_nxt = S_IDLE;
                else if (frame_full) state_nxt = S_CHECK;
                else if (done)       state_nxt = S_IDLE;
            end
            S_CHECK: begin
                if (check_pass) state_nxt = S_SEND;
                else            state_nxt = S_IDLE;
            end
            S_SEND: begin
                if (xfer && out_last) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt    <= 7'd0;
            low_cnt    <= 6'd0;
            crc        <= 24'd0;
            parity     <= 24'd0;
            shreg      <= 112'd0;
            df         <= 5'd0;
            byte_idx   <= 5'd0;
            out_data   <= 8'd0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            frames_ok  <= 16'd0;
            frames_bad <= 16'd0;
            overrun    <= 1'b0;
        end else begin
            overrun <= (state == S_SEND) && data_start;

            if ((state == S_IDLE) && (state_nxt == S_COLLECT)) begin
                bit_cnt <= 7'd0;
                low_cnt <= 6'd0;
                crc     <= 24'd0;
                parity  <= 24'd0;
                shreg   <= 112'd0;
                df      <= 5'd0;
            end

            if (bit_take) begin
                shreg   <= {shreg[110:0], bit_data};
                bit_cnt <= bit_num;
                if (!bit_conf && (low_cnt != 6'd63)) low_cnt <= low_cnt + 6'd1;
                if (bit_cnt == 7'd4) df <= {shreg[3:0], bit_data};
                if (in_crc_region)
                    crc <= {crc[22:0], 1'b0} ^ ((crc[23] ^ bit_data) ? CRC_POLY : 24'd0);
                else
                    parity <= {parity[22:0], bit_data};
            end

            if (drop_early || check_drop) frames_bad <= frames_bad + 16'd1;

            if (check_pass) begin
                frames_ok <= frames_ok + 16'd1;
                out_valid <= 1'b1;
                out_data  <= header;
                out_last  <= 1'b0;
                byte_idx  <= 5'd1;
            end

            if (xfer) begin
                if (out_last) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end else begin
                    out_data <= nxt_byte;
                    out_last <= (byte_idx == last_idx);
                    byte_idx <= byte_idx + 5'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_adsb_frame_asm.sv
// Self-checking bench for adsb_frame_asm; expected record bytes are queued when a frame is driven.
// Expectations follow ADSB_CRC_REJECT_EN when the bench is built with it defined.
module tb_adsb_frame_asm;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        det_ena = 1'b1;
    logic        data_start = 1'b0;
    logic        bit_ena = 1'b0;
    logic        bit_data = 1'b0;
    logic        bit_conf = 1'b1;
    logic        done = 1'b0;
    logic        watchdog_reset = 1'b0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last;
    logic [15:0] frames_ok;
    logic [15:0] frames_bad;
    logic        overrun;
    logic [1:0]  state_dbg;

    int errors = 0;
    int checks = 0;
    int exp_ok = 0;
    int exp_bad = 0;
    logic rand_ready = 1'b0;

    logic [8:0] exp_q[$];

    localparam logic [111:0] LONG_FRAME  = 112'h8D4840D6202CC371C32CE0576098;
    localparam logic [111:0] SHORT_FRAME = {56'd0, 56'h20001838CA3804};

    adsb_frame_asm #(.CONF_MAX(8)) dut (
        .clock(clock), .reset(reset), .det_ena(det_ena), .data_start(data_start),
        .bit_ena(bit_ena), .bit_data(bit_data), .bit_conf(bit_conf), .done(done),
        .watchdog_reset(watchdog_reset), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .frames_ok(frames_ok),
        .frames_bad(frames_bad), .overrun(overrun), .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    // Scoreboard: every accepted byte is popped and compared as {last, data}.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL stream_extra got last=%b data=%02h required none", out_last, out_data);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if ({out_last, out_data} !== e) begin
                    errors++;
                    $display("FAIL stream_byte got last=%b data=%02h required last=%b data=%02h",
                             out_last, out_data, e[8], e[7:0]);
                end
            end
        end
    end

    // Reference syndrome: remainder of the whole frame divided by x^24 + 0xFFF409.
    function automatic logic [23:0] ref_syndrome(input logic [111:0] f, input int nbits);
        logic [111:0] d;
        d = f;
        for (int i = nbits - 1; i >= 24; i--)
            if (d[i]) d[i -: 25] = d[i -: 25] ^ 25'h1FFF409;
        return d[23:0];
    endfunction

    function automatic int count_bad(input logic [111:0] bad, input int nbits);
        int c;
        c = 0;
        for (int i = 0; i < nbits; i++) if (bad[i]) c++;
        return (c > 63) ? 63 : c;
    endfunction

    task automatic push_record(input logic [111:0] f, input int nbits, input int lowc);
        logic [23:0] syn;
        logic [7:0]  hdr;
        syn = ref_syndrome(f, nbits);
        hdr = {(nbits == 112), (syn == 24'd0), 6'(lowc)};
        exp_q.push_back({1'b0, hdr});
        for (int j = 0; j < nbits / 8; j++) exp_q.push_back({1'b0, f[nbits - 1 - 8 * j -: 8]});
        exp_q.push_back({1'b0, syn[23:16]});
        exp_q.push_back({1'b0, syn[15:8]});
        exp_q.push_back({1'b1, syn[7:0]});
    endtask

    // cut_kind: 0 none, 1 done pulse, 2 watchdog with a bit strobe, 3 det_ena low.
    task automatic drive_frame(input logic [111:0] f, input int nbits, input logic [111:0] bad,
                               input int cut_at, input int cut_kind);
        data_start = 1'b1;
        @(posedge clock); #1;
        data_start = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
            if (i == cut_at) begin
                case (cut_kind)
                    1: done = 1'b1;
                    2: begin watchdog_reset = 1'b1; bit_ena = 1'b1; bit_data = f[nbits - 1 - i]; end
                    default: det_ena = 1'b0;
                endcase
                @(posedge clock); #1;
                done = 1'b0; watchdog_reset = 1'b0; bit_ena = 1'b0; det_ena = 1'b1;
                return;
            end
            bit_ena  = 1'b1;
            bit_data = f[nbits - 1 - i];
            bit_conf = !bad[nbits - 1 - i];
            @(posedge clock); #1;
            bit_ena  = 1'b0;
            bit_conf = 1'b1;
        end
    endtask

    task automatic wait_record(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 400) begin
            @(posedge clock); #1;
            n++;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL %s_timeout got pending=%0d required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_counters(input string name);
        checks++;
        if (frames_ok !== 16'(exp_ok) || frames_bad !== 16'(exp_bad) || state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL %s_counters got ok=%0d bad=%0d state=%0d required ok=%0d bad=%0d state=0",
                     name, frames_ok, frames_bad, state_dbg, exp_ok, exp_bad);
        end
    endtask

    task automatic idle_quiet(input string name);
        repeat (6) begin
            @(posedge clock); #1;
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_no_output got out_valid=%b required 0", name, out_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({out_data, out_valid, out_last, frames_ok, frames_bad, overrun, state_dbg} !== '0) begin
            errors++;
            $display("FAIL reset_values got data=%02h v=%b l=%b ok=%0d bad=%0d ovr=%b st=%0d required all 0",
                     out_data, out_valid, out_last, frames_ok, frames_bad, overrun, state_dbg);
        end
        reset = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (state_dbg !== 2'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got state=%0d v=%b required state=0 v=0", state_dbg, out_valid);
        end
    endtask

    task automatic test_long_frame();
        logic [111:0] f;
        f = LONG_FRAME;
        exp_q.push_back({1'b0, 8'hC0});
        for (int j = 0; j < 14; j++) exp_q.push_back({1'b0, f[111 - 8 * j -: 8]});
        exp_q.push_back({1'b0, 8'h00});
        exp_q.push_back({1'b0, 8'h00});
        exp_q.push_back({1'b1, 8'h00});
        drive_frame(f, 112, '0, -1, 0);
        checks++;
        if (state_dbg !== 2'd2 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL long_check_cycle got state=%0d v=%b required state=2 v=0", state_dbg, out_valid);
        end
        @(posedge clock); #1;
        checks++;
        if (state_dbg !== 2'd3 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL long_send_cycle got state=%0d v=%b required state=3 v=1", state_dbg, out_valid);
        end
        wait_record("long");
        exp_ok++;
        check_counters("long");
    endtask

    task automatic test_crc_error();
        logic [111:0] f;
        f = LONG_FRAME ^ (112'd1 << 72);
`ifdef ADSB_CRC_REJECT_EN
        drive_frame(f, 112, '0, -1, 0);
        idle_quiet("crc_reject");
        exp_bad++;
`else
        push_record(f, 112, 0);
        drive_frame(f, 112, '0, -1, 0);
        wait_record("crc_forward");
        exp_ok++;
`endif
        check_counters("crc");
    endtask

    task automatic test_short_frame();
        push_record(SHORT_FRAME, 56, 0);
        drive_frame(SHORT_FRAME, 56, '0, -1, 0);
        wait_record("short");
        exp_ok++;
        check_counters("short");
    endtask

    task automatic test_aborts();
        drive_frame(LONG_FRAME, 112, '0, 30, 1);
        idle_quiet("done_early");
        exp_bad++;
        check_counters("done_early");
        drive_frame(LONG_FRAME, 112, '0, 49, 2);
        idle_quiet("watchdog");
        check_counters("watchdog");
        drive_frame(SHORT_FRAME, 56, '0, 20, 3);
        idle_quiet("det_ena_low");
        check_counters("det_ena_low");
        data_start = 1'b1; watchdog_reset = 1'b1;
        @(posedge clock); #1;
        data_start = 1'b0; watchdog_reset = 1'b0;
        checks++;
        if (state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL start_with_watchdog got state=%0d required 0", state_dbg);
        end
        det_ena = 1'b0; data_start = 1'b1;
        @(posedge clock); #1;
        det_ena = 1'b1; data_start = 1'b0;
        checks++;
        if (state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL start_detect_off got state=%0d required 0", state_dbg);
        end
    endtask

    task automatic test_confidence();
        logic [111:0] bad;
        bad = '0;
        for (int k = 0; k < 9; k++) bad[100 - 10 * k] = 1'b1;
        drive_frame(LONG_FRAME, 112, bad, -1, 0);
        idle_quiet("conf_9");
        exp_bad++;
        check_counters("conf_9");
        bad[20] = 1'b0;
        push_record(LONG_FRAME, 112, count_bad(bad, 112));
        drive_frame(LONG_FRAME, 112, bad, -1, 0);
        wait_record("conf_8");
        exp_ok++;
        check_counters("conf_8");
    endtask

    task automatic test_backpressure();
        logic [8:0] held;
        int n;
        out_ready = 1'b0;
        push_record(LONG_FRAME, 112, 0);
        drive_frame(LONG_FRAME, 112, '0, -1, 0);
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clock); #1; n++; end
        held = {out_last, out_data};
        for (int k = 0; k < 20; k++) begin
            if (k == 5) data_start = 1'b1;
            @(posedge clock); #1;
            data_start = 1'b0;
            checks++;
            if ({out_valid, out_last, out_data} !== {1'b1, held}) begin
                errors++;
                $display("FAIL stall_hold cycle=%0d got v=%b l=%b d=%02h required v=1 l=%b d=%02h",
                         k, out_valid, out_last, out_data, held[8], held[7:0]);
            end
            checks++;
            if (overrun !== (k == 5)) begin
                errors++;
                $display("FAIL overrun_pulse cycle=%0d got %b required %b", k, overrun, (k == 5));
            end
        end
        out_ready = 1'b1;
        wait_record("stall");
        exp_ok++;
        check_counters("stall");
    endtask

    task automatic test_back_to_back();
        logic [127:0] r;
        logic [111:0] f;
        rand_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            r = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (k[0]) begin
                f = {56'd0, 5'd5, r[50:0]};
                push_record(f, 56, 0);
                drive_frame(f, 56, '0, -1, 0);
            end else begin
                f = {5'd20, r[106:0]};
                push_record(f, 112, 0);
                drive_frame(f, 112, '0, -1, 0);
            end
            wait_record("b2b");
            exp_ok++;
        end
        rand_ready = 1'b0;
        check_counters("b2b");
    endtask

    initial begin
        test_reset();
        test_long_frame();
        test_crc_error();
        test_short_frame();
        test_aborts();
        test_confidence();
        test_backpressure();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adsb_frame_asm.md
# adsb_frame_asm

Frame assembler downstream of the ADS-B receiver: collects demodulated PPM bits (`ena_out`/`data`/`conf`/`done`/`data_start` of the receiver) into 56- or 112-bit Mode S frames. It computes the CRC-24 serially while bits arrive and tags each frame with status and syndrome. Completed frames are emitted as a byte stream with a valid/ready handshake toward the host FIFO.

## Interface
Parameters:
- `CONF_MAX`, 8: frames with more low-confidence bits than this are discarded.

Ports:
- `clock` in 1: system clock. One clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `det_ena` in 1: detection enable. Low forces IDLE and blocks new frames.
- `data_start` in 1: preamble found, one-cycle pulse.
- `bit_ena` in 1: bit strobe, one cycle per decoded bit.
- `bit_data` in 1: bit value, valid when `bit_ena`.
- `bit_conf` in 1: bit confidence (1 = good), valid when `bit_ena`.
- `done` in 1: demodulator frame-end pulse.
- `watchdog_reset` in 1: receiver watchdog clear; aborts the current frame.
- `out_data` out 8: stream byte.
- `out_valid` out 1: byte valid.
- `out_ready` in 1: consumer accepts the byte.
- `out_last` out 1: final byte of a record.
- `frames_ok` out 16: count of frames emitted, wrapping.
- `frames_bad` out 16: count of frames dropped for length, confidence or CRC, wrapping.
- `overrun` out 1: one-cycle pulse when `data_start` arrives while in SEND.

## Operation
- States: IDLE, COLLECT, CHECK, SEND.
- IDLE -> COLLECT on `data_start` && `det_ena`. On entry, clear the bit counter (7 bits), the low-conf counter (saturating at 63), the CRC register and the 112-bit shift register.
- COLLECT, on each `bit_ena`:
  - Shift `bit_data` in, MSB first.
  - Increment the bit count.
  - If `bit_conf` == 0, increment the low-conf count.
- Length `n` is latched after bit 5: DF = first 5 bits; DF >= 16 gives n = 112, otherwise n = 56.
- CRC: poly 0xFFF409 (x^24 implied), register init 0.
  - Bits 1..n-24: crc <= {crc[22:0],1'b0} ^ ((crc[23]^bit) ? 24'hFFF409 : 0).
  - Bits n-23..n: shifted into a separate 24-bit parity register.
  - Syndrome = crc ^ parity.
- COLLECT -> CHECK when the bit count reaches n.
  - `done` before n bits: frame dropped, `frames_bad`++, -> IDLE.
  - `done` at or after n: ignored.
- CHECK (1 cycle). The frame is dropped (`frames_bad`++, -> IDLE) if low-conf > `CONF_MAX`, or if a CRC reject applies per Configuration. Otherwise `frames_ok`++ and -> SEND.
- SEND emits a record of 1 + n/8 + 3 bytes (11 bytes for short, 18 for long):
  - Header: bit7 = long, bit6 = crc_ok (syndrome == 0), bits5:0 = low-conf count.
  - Frame bytes, MSB first.
  - Syndrome bytes [23:16], [15:8], [7:0].
  - `out_last` is asserted with the final syndrome byte.
  - After the last byte is accepted -> IDLE.
- `watchdog_reset` or `det_ena` low in COLLECT/CHECK: abort -> IDLE with no counter change. SEND is never aborted by either; the record always completes.
- `data_start` in COLLECT/CHECK: ignored. In SEND: `overrun` pulse, and the frame is lost (not counted in `frames_bad`).
- Simultaneous events:
  - `bit_ena` and `watchdog_reset` in the same cycle: abort wins, the bit is discarded.
  - `data_start` and `watchdog_reset` in IDLE: stay in IDLE.

## Timing
- Reset values: `out_data` 0, `out_valid` 0, `out_last` 0, `frames_ok` 0, `frames_bad` 0, `overrun` 0. State IDLE.
- `data_start` at cycle t: state COLLECT at t+1, so `bit_ena` is accepted from t+1.
- Final bit `bit_ena` at t: CHECK at t+1; `out_valid` = 1 with the header at t+2 (SEND).
- Handshake:
  - A byte transfers on a cycle where `out_valid` && `out_ready`.
  - `out_data` and `out_last` hold stable while `out_valid` && !`out_ready`.
  - `out_valid` never drops mid-record.
  - Full throughput is 1 byte/cycle.
- `out_valid` deasserts the cycle after the last-byte transfer.
- Counters update the cycle after CHECK.

## Configuration
- `ADSB_CRC_REJECT_EN` defined: in CHECK, frames with DF 11, 17 or 18 and a nonzero syndrome are dropped and counted in `frames_bad`. Other DFs (address/parity overlaid) are always forwarded with their syndrome.
- `ADSB_CRC_REJECT_EN` undefined: no CRC-based drop. The CRC is still computed; header bit6 and the syndrome bytes are still valid.

## Test plan
- Long frame 0x8D4840D6202CC371C32CE0576098, all conf = 1, `out_ready` = 1 -> 18 bytes: header 0xC0, then 8D 48 40 D6 20 2C C3 71 C3 2C E0 57 60 98, then 00 00 00 with `out_last`; `frames_ok` = 1.
- Same frame with bit 40 inverted -> with `ADSB_CRC_REJECT_EN`: no output, `frames_bad` = 1. Without it: header 0x80, nonzero syndrome.
- DF4 short frame (first byte 0x20), 56 bits -> 11-byte record, header bit7 = 0, `out_last` on byte 11.
- `done` after 30 bits -> no output, `frames_bad`++, IDLE. `watchdog_reset` at bit 50 -> no output, counters unchanged.
- Long frame with 9 bits `bit_conf` = 0 (`CONF_MAX` = 8) -> dropped. The same frame with 8 low-conf bits is emitted with header bits5:0 = 8.
- Valid frame with `out_ready` held low for 20 cycles, plus `data_start` pulsed during SEND -> `out_data`/`out_valid` held stable, one `overrun` pulse, the record completes intact after `out_ready` rises.
